// File: rtl/pool_ch_scheduler.sv
// Round-robin scheduler that time-shares one maxpooler among N_CH channel streams, one map per grant.
// Define POOL_SCHED_ERR_EN to enable the per-map result-count check that drives err.
module pool_ch_scheduler #(
    parameter int FM_ROW = 12,
    parameter int FM_COL = 12,
    parameter int P      = 3,
    parameter int N_DATA = 32,
    parameter int N_CH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            ch_req,
    input  logic [N_CH-1:0]            ch_vld,
    input  logic [N_CH*N_DATA-1:0]     ch_data,
    output logic [N_CH-1:0]            ch_rdy,
    output logic [N_CH-1:0]            ch_gnt,
    output logic                       pool_rst,
    output logic                       pool_in_vld,
    output logic [N_DATA-1:0]          pool_in_data,
    input  logic                       pool_out_vld,
    input  logic [N_DATA-1:0]          pool_out_data,
    input  logic                       pool_out_end,
    output logic                       res_vld,
    output logic [N_DATA-1:0]          res_data,
    output logic [$clog2(N_CH)-1:0]    res_ch,
    output logic                       res_last,
    output logic                       busy,
    output logic                       err
);
    localparam int IN_CNT = FM_ROW * FM_COL;
    localparam int IDX_W  = $clog2(N_CH);
    localparam int CNT_W  = $clog2(IN_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [N_CH-1:0]    r_gnt;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [N_DATA-1:0]  w_ch_data [N_CH];
    logic [IDX_W-1:0]   w_rr_idx;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_vld;
    logic [N_CH-1:0]    w_win_onehot;
    logic               w_stream;
    logic               w_res_on;
    logic               w_accept;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign w_ch_data[gi] = ch_data[gi*N_DATA +: N_DATA];
    end

    // Walk the ring from last+1; the first requester met wins.
    always_comb begin
        w_rr_idx  = r_last;
        w_win_idx = '0;
        w_win_vld = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_rr_idx = (w_rr_idx == IDX_W'(N_CH - 1)) ? '0 : w_rr_idx + 1'b1;
            if (!w_win_vld && ch_req[w_rr_idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_rr_idx;
            end
        end
    end

    assign w_win_onehot = N_CH'(1) << w_win_idx;
    assign w_stream     = (r_state == S_STREAM);
    assign w_res_on     = (r_state == S_STREAM) || (r_state == S_DRAIN);
    assign w_accept     = w_stream && ch_vld[r_gidx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_last  <= IDX_W'(N_CH - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_gnt   <= w_win_onehot;
                        r_gidx  <= w_win_idx;
                        r_busy  <= 1'b1;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_cnt   <= '0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    // A stray pool_out_end here is only forwarded; the full map must still be fed.
                    if (w_accept) begin
                        if (r_cnt == CNT_W'(IN_CNT - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pool_out_end) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_gidx;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ch_gnt       = r_gnt;
    assign ch_rdy       = w_stream ? r_gnt : '0;
    assign busy         = r_busy;
    assign pool_rst     = rst || (r_state == S_CLR);
    assign pool_in_vld  = w_accept;
    assign pool_in_data = w_stream ? w_ch_data[r_gidx] : '0;
    assign res_vld      = w_res_on && pool_out_vld;
    assign res_data     = w_res_on ? pool_out_data : '0;
    assign res_last     = w_res_on && pool_out_end;
    assign res_ch       = w_res_on ? r_gidx : '0;

`ifdef POOL_SCHED_ERR_EN
    localparam int OUT_CNT = (FM_ROW / P) * (FM_COL / P);
    localparam int RC_W    = $clog2(IN_CNT + 1);

    logic [RC_W-1:0] r_res_cnt;
    logic            r_err;

    // Count results per map; the last one must be exactly the OUT_CNT-th.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_CLR) begin
                r_res_cnt <= '0;
            end else if (res_vld) begin
                r_res_cnt <= r_res_cnt + 1'b1;
            end
            if (res_vld && res_last && ((r_res_cnt + 1'b1) != RC_W'(OUT_CNT))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pool_ch_scheduler.sv
// Directed bench for pool_ch_scheduler: a stub maxpooler, a map-level reference model
// checked against the DUT every cycle, and literal expectations per scenario.
module tb_pool_ch_scheduler;
    localparam int FM_ROW  = 12;
    localparam int FM_COL  = 12;
    localparam int P       = 3;
    localparam int N_DATA  = 32;
    localparam int N_CH    = 4;
    localparam int IDX_W   = 2;
    localparam int IN_CNT  = FM_ROW * FM_COL;
    localparam int OUT_CNT = (FM_ROW / P) * (FM_COL / P);
`ifdef POOL_SCHED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CH-1:0]         ch_req;
    logic [N_CH-1:0]         ch_vld;
    logic [N_CH*N_DATA-1:0]  ch_data;
    logic [N_CH-1:0]         ch_rdy;
    logic [N_CH-1:0]         ch_gnt;
    logic                    pool_rst;
    logic                    pool_in_vld;
    logic [N_DATA-1:0]       pool_in_data;
    logic                    po_vld = 1'b0;
    logic [N_DATA-1:0]       po_data = '0;
    logic                    po_end = 1'b0;
    logic                    res_vld;
    logic [N_DATA-1:0]       res_data;
    logic [IDX_W-1:0]        res_ch;
    logic                    res_last;
    logic                    busy;
    logic                    err;

    pool_ch_scheduler #(
        .FM_ROW(FM_ROW), .FM_COL(FM_COL), .P(P), .N_DATA(N_DATA), .N_CH(N_CH)
    ) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_vld(ch_vld), .ch_data(ch_data),
        .ch_rdy(ch_rdy), .ch_gnt(ch_gnt), .pool_rst(pool_rst), .pool_in_vld(pool_in_vld),
        .pool_in_data(pool_in_data), .pool_out_vld(po_vld), .pool_out_data(po_data),
        .pool_out_end(po_end), .res_vld(res_vld), .res_data(res_data), .res_ch(res_ch),
        .res_last(res_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit early_end = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL timeout %s: event not seen within its cycle budget", nm);
    endtask

    function automatic logic bit_at(input logic [N_CH-1:0] v, input int j);
        return v[j[IDX_W-1:0]];
    endfunction

    // Channel sources: ramp words, advancing on each handshake.
    logic [N_DATA-1:0] src_cnt [N_CH];
    logic [N_DATA-1:0] ch_word [N_CH];
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_src
        assign ch_word[gi] = N_DATA'(gi * 4096) + src_cnt[gi];
        assign ch_data[gi*N_DATA +: N_DATA] = ch_word[gi];
        initial begin
            src_cnt[gi] = '0;
            forever begin
                @(posedge clk);
                if (rst) src_cnt[gi] <= '0;
                else if (ch_rdy[gi] && ch_vld[gi]) src_cnt[gi] <= src_cnt[gi] + 1;
            end
        end
    end

    // Stub maxpooler: one result the cycle after each window completes.
    int pk = 0;
    int pres = 0;
    logic [N_DATA-1:0] wmax [256];
    initial forever begin
        int r, c, w;
        @(posedge clk);
        po_vld <= 1'b0;
        po_end <= 1'b0;
        if (pool_rst) begin
            pk = 0;
            pres = 0;
        end else if (pool_in_vld) begin
            r = pk / FM_COL;
            c = pk % FM_COL;
            w = (r / P) * (FM_COL / P) + c / P;
            if ((r % P == 0) && (c % P == 0)) wmax[w[7:0]] = pool_in_data;
            else if (pool_in_data > wmax[w[7:0]]) wmax[w[7:0]] = pool_in_data;
            if ((r % P == P - 1) && (c % P == P - 1)) begin
                pres++;
                po_vld  <= 1'b1;
                po_data <= wmax[w[7:0]];
                po_end  <= (pres == OUT_CNT) || (early_end && pres == OUT_CNT - 1);
            end
            pk++;
        end
    end

    // Reference model: phase 0 idle, 1 clear, 2 stream, 3 drain.
    int m_ph = 0, m_g = 0, m_last = N_CH - 1, m_words = 0, m_rcnt = 0;
    bit m_err = 1'b0;
    initial forever begin
        bit found;
        @(posedge clk);
        if (rst) begin
            m_ph = 0; m_last = N_CH - 1; m_words = 0; m_rcnt = 0; m_err = 1'b0;
        end else begin
            if ((m_ph == 2 || m_ph == 3) && po_vld) begin
                m_rcnt++;
                if (po_end && m_rcnt != OUT_CNT) m_err = ERR_EN;
            end
            case (m_ph)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= N_CH; k++) begin
                        if (!found && bit_at(ch_req, (m_last + k) % N_CH)) begin
                            found = 1'b1;
                            m_g = (m_last + k) % N_CH;
                        end
                    end
                    if (found) begin m_ph = 1; m_words = 0; end
                end
                1: begin m_ph = 2; m_rcnt = 0; end
                2: if (bit_at(ch_vld, m_g)) begin
                    m_words++;
                    if (m_words == IN_CNT) m_ph = 3;
                end
                default: if (po_end) begin m_ph = 0; m_last = m_g; end
            endcase
        end
    end

    // DUT-side observations used by the literal scenario checks.
    int cyc = 0, obs_in = 0, obs_res = 0, obs_last_at = 0, obs_stream = 0;
    int t_last = 0, t_gnt = 0, rdy_overlap = 0;
    logic [N_DATA-1:0] first_rd, last_rd;
    logic [N_CH-1:0] obs_ch_or, prev_gnt = '0;
    logic [N_CH-1:0] gq [$];
    logic [N_CH-1:0] e_gnt;
    bit e_on;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_on  = (m_ph == 2) || (m_ph == 3);
            e_gnt = (m_ph != 0) ? (N_CH'(1) << m_g) : '0;
            chk("gnt", 64'(ch_gnt), 64'(e_gnt));
            chk("rdy", 64'(ch_rdy), 64'((m_ph == 2) ? e_gnt : '0));
            chk("pin_vld", 64'(pool_in_vld), 64'((m_ph == 2) && bit_at(ch_vld, m_g)));
            chk("pin_data", 64'(pool_in_data), 64'((m_ph == 2) ? ch_word[m_g[IDX_W-1:0]] : '0));
            chk("pool_rst", 64'(pool_rst), 64'(rst || m_ph == 1));
            chk("res_vld", 64'(res_vld), 64'(e_on && po_vld));
            chk("res_data", 64'(res_data), 64'(e_on ? po_data : '0));
            chk("res_last", 64'(res_last), 64'(e_on && po_end));
            chk("res_ch", 64'(res_ch), 64'(e_on ? m_g : 0));
            chk("busy", 64'(busy), 64'(m_ph != 0));
            chk("err", 64'(err), 64'(m_err));
            if (pool_rst && !rst) begin
                obs_in = 0; obs_res = 0; obs_last_at = 0; obs_stream = 0; obs_ch_or = '0;
            end
            if (pool_in_vld) obs_in++;
            if (ch_rdy != '0) obs_stream++;
            if ($countones(ch_rdy) > 1) rdy_overlap++;
            if (res_vld) begin
                obs_res++;
                if (obs_res == 1) first_rd = res_data;
                last_rd = res_data;
                obs_ch_or = obs_ch_or | (N_CH'(1) << res_ch);
                if (res_last) begin obs_last_at = obs_res; t_last = cyc; end
            end
            if (ch_gnt != '0 && prev_gnt == '0) begin gq.push_back(ch_gnt); t_gnt = cyc; end
            prev_gnt = ch_gnt;
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_map(input int budget, input string nm);
        int n = 0;
        while (busy !== 1'b1 && n < budget) begin step(1); n++; end
        ch_req = '0;
        while (busy !== 1'b0 && n < budget) begin step(1); n++; end
        if (n >= budget) fail_to(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_CH-1:0] rr_exp [5];
        int n;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; ch_req = '0; ch_vld = '0;
        step(1);
        chk_en = 1'b1;
        step(1);
        chk("rst_pool_rst", 64'(pool_rst), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gnt", 64'(ch_gnt), 64'(0));
        chk("rst_rdy", 64'(ch_rdy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        step(1);
        chk("idle_pool_rst", 64'(pool_rst), 64'(0));

        // Single map on channel 0; the request drops right after the grant.
        ch_vld = '1; ch_req = 4'b0001;
        run_map(400, "single");
        chk("single_in", 64'(obs_in), 64'(144));
        chk("single_res", 64'(obs_res), 64'(16));
        chk("single_last_at", 64'(obs_last_at), 64'(16));
        chk("single_ch", 64'(obs_ch_or), 64'(4'b0001));
        chk("single_first", 64'(first_rd), 64'(26));
        chk("single_lastdata", 64'(last_rd), 64'(143));
        chk("single_busy", 64'(busy), 64'(0));

        // Round robin with every channel requesting.
        rst = 1'b1; step(1); rst = 1'b0;
        gq.delete();
        rdy_overlap = 0;
        ch_req = '1;
        n = 0;
        while (gq.size() < 5 && n < 1500) begin step(1); n++; end
        if (n >= 1500) fail_to("rr_grants");
        run_map(400, "rr_tail");
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), 64'((i < gq.size()) ? gq[i] : '0), 64'(rr_exp[i]));
        chk("rr_overlap", 64'(rdy_overlap), 64'(0));

        // Bubbles: valid alternates 0,1 across the stream window.
        ch_vld = '0; ch_req = 4'b0010;
        step(1);
        ch_req = '0;
        step(1);
        for (int c = 0; c < 288; c++) begin
            ch_vld = (c % 2 == 1) ? '1 : '0;
            step(1);
        end
        ch_vld = '0;
        run_map(100, "bubble");
        chk("bubble_stream", 64'(obs_stream), 64'(288));
        chk("bubble_in", 64'(obs_in), 64'(144));
        chk("bubble_res", 64'(obs_res), 64'(16));
        chk("bubble_ch", 64'(obs_ch_or), 64'(4'b0010));

        // Reset after 70 accepted words, then a fresh map.
        ch_vld = '1; ch_req = 4'b0001;
        n = 0;
        while (!(m_ph == 2 && m_words >= 70) && n < 400) begin step(1); n++; end
        if (n >= 400) fail_to("mid_reset_reach");
        rst = 1'b1;
        step(1);
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_gnt", 64'(ch_gnt), 64'(0));
        chk("midrst_res", 64'(res_vld), 64'(0));
        rst = 1'b0;
        run_map(400, "mid_reset_rerun");
        chk("midrst_in", 64'(obs_in), 64'(144));
        chk("midrst_resn", 64'(obs_res), 64'(16));
        chk("midrst_last_at", 64'(obs_last_at), 64'(16));

        // Pooler ends early on the 15th result.
        early_end = 1'b1; ch_req = 4'b0001;
        run_map(400, "err_map");
        chk("err_set", 64'(err), 64'(ERR_EN));
        step(5);
        chk("err_hold", 64'(err), 64'(ERR_EN));
        early_end = 1'b0;
        rst = 1'b1; step(1); rst = 1'b0;
        chk("err_clear", 64'(err), 64'(0));

        // Late request from channel 2 during a channel 0 map.
        ch_req = 4'b0001;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin step(1); n++; end
        ch_req = '0;
        step(50);
        ch_req = 4'b0100;
        n = 0;
        while (ch_gnt !== 4'b0100 && n < 400) begin step(1); n++; end
        if (n >= 400) fail_to("late_grant");
        ch_req = '0;
        step(1);
        chk("late_gap", 64'(t_gnt - t_last), 64'(2));
        chk("late_prev", 64'((gq.size() >= 2) ? gq[gq.size()-2] : '0), 64'(4'b0001));
        chk("late_new", 64'((gq.size() >= 1) ? gq[gq.size()-1] : '0), 64'(4'b0100));
        run_map(400, "late_map");
        chk("late_res", 64'(obs_res), 64'(16));
        chk("late_ch", 64'(obs_ch_or), 64'(4'b0100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
